iir_biquad_cascade: RTL and testbench

//  Parametrised successor to the first-order IIR: N_SECTIONS cascaded Direct-Form-I biquads

---
 rtl/iir_pkg.sv | 24 ++
 rtl/iir_mac.sv | 37 +++
 rtl/iir_biquad_cascade.sv | 130 +++++++++++++
 tb/tb_iir_biquad_cascade.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, default widths and saturation helper for the biquad cascade
package iir_pkg;
  localparam int N_BITS_DEF     = 32;
  localparam int FRAC_BITS_DEF  = 16;
  localparam int N_SECTIONS_DEF = 2;
  localparam int GUARD_BITS_DEF = 4;
  localparam int ACC_W          = 2 * N_BITS_DEF + GUARD_BITS_DEF;
  // Wide scratch width for rounding/offset math so no intermediate can wrap
  localparam int SAT_W          = 128;

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_t;

  function automatic logic signed [SAT_W-1:0] sat_n(input logic signed [SAT_W-1:0] v,
                                                    input int n);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (n - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared multiply/accumulate with round-and-saturate readout
module iir_mac
  import iir_pkg::*;
#(
  parameter int N_BITS    = N_BITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACCW      = ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [N_BITS-1:0] coef,
  input  logic signed [N_BITS-1:0] operand,
  output logic signed [N_BITS-1:0] y
);
  logic signed [ACCW-1:0]     acc_q;
  logic signed [2*N_BITS-1:0] prod;
  logic signed [SAT_W-1:0]    rounded;

  always_comb begin
    prod    = (2*N_BITS)'(coef) * (2*N_BITS)'(operand);
    rounded = (SAT_W'(acc_q) + (SAT_W'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    y       = N_BITS'(sat_n(rounded, N_BITS));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sub ? acc_q - ACCW'(prod) : acc_q + ACCW'(prod);
    end
  end
endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - N cascaded DF-I biquads time-sharing one MAC, with coefficient file
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int N_SECTIONS = N_SECTIONS_DEF,
  parameter int GUARD_BITS = GUARD_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_BITS-1:0]                 x_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [N_BITS-1:0]                 offset_i,
  input  logic                              clear_i,
  input  logic                              coef_we_i,
  input  logic [$clog2(5*N_SECTIONS)-1:0]   coef_addr_i,
  input  logic [N_BITS-1:0]                 coef_data_i,
  output logic [N_BITS-1:0]                 y_o,
  output logic                              valid_o
);
  localparam int N_COEF = 5 * N_SECTIONS;
  localparam int AW     = $clog2(N_COEF);
  localparam int SW     = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;

  state_t state_q, state_d;
  tap_t   tap_q;
  logic [SW-1:0]            sec_q;
  logic                     run_q, valid_q, pend_q;
  logic [AW-1:0]            pend_addr_q, coef_idx;
  logic signed [N_BITS-1:0] pend_data_q, x_q, y_q, cur_coef, operand, mac_y, y_final;
  logic signed [N_BITS-1:0] coef_q [N_COEF];
  logic signed [N_BITS-1:0] x1_q [N_SECTIONS];
  logic signed [N_BITS-1:0] x2_q [N_SECTIONS];
  logic signed [N_BITS-1:0] y1_q [N_SECTIONS];
  logic signed [N_BITS-1:0] y2_q [N_SECTIONS];
  logic ready, accept, coef_ok, last_sec, sub;

  always_comb begin
    ready    = (state_q == IDLE) && run_q;
    accept   = ready && valid_i && !clear_i;
    coef_ok  = ready && coef_we_i && (int'(coef_addr_i) < N_COEF);
    last_sec = (int'(sec_q) == N_SECTIONS - 1);
    coef_idx = AW'(int'(sec_q) * 5 + int'(tap_q));
    cur_coef = coef_q[coef_idx];
    y_final  = N_BITS'(sat_n(SAT_W'(mac_y) + SAT_W'(signed'(offset_i)), N_BITS));
    operand  = x_q;
    sub      = 1'b0;
    case (tap_q)
      B1: operand = x1_q[sec_q];
      B2: operand = x2_q[sec_q];
      A1: begin operand = y1_q[sec_q]; sub = 1'b1; end
      A2: begin operand = y2_q[sec_q]; sub = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (tap_q == A2) state_d = ROUND;
      ROUND:   state_d = last_sec ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  iir_mac #(.N_BITS(N_BITS), .FRAC_BITS(FRAC_BITS), .ACCW(2*N_BITS+GUARD_BITS)) u_mac (
    .clk(clk), .reset(reset), .clr(accept || (state_q == ROUND)), .en(state_q == MAC),
    .sub(sub), .coef(cur_coef), .operand(operand), .y(mac_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0; valid_q <= 1'b0; pend_q <= 1'b0;
      pend_addr_q <= '0; pend_data_q <= '0;
      tap_q <= B0; sec_q <= '0; x_q <= '0; y_q <= '0;
      for (int i = 0; i < N_COEF; i++) coef_q[i] <= '0;
      for (int s = 0; s < N_SECTIONS; s++) begin
        x1_q[s] <= '0; x2_q[s] <= '0; y1_q[s] <= '0; y2_q[s] <= '0;
      end
    end else begin
      run_q   <= 1'b1;
      valid_q <= 1'b0;
      // A write landing with a sample is deferred so that sample sees the old taps
      if (coef_ok) begin
        if (accept) begin
          pend_q <= 1'b1; pend_addr_q <= coef_addr_i; pend_data_q <= coef_data_i;
        end else begin
          coef_q[coef_addr_i] <= coef_data_i;
        end
      end
      if (ready && clear_i) begin
        for (int s = 0; s < N_SECTIONS; s++) begin
          x1_q[s] <= '0; x2_q[s] <= '0; y1_q[s] <= '0; y2_q[s] <= '0;
        end
      end
      if (accept) x_q <= x_i;
      if (state_q == MAC) tap_q <= (tap_q == A2) ? B0 : tap_t'(tap_q + 3'd1);
      if (state_q == ROUND) begin
        x2_q[sec_q] <= x1_q[sec_q];
        x1_q[sec_q] <= x_q;
        y2_q[sec_q] <= y1_q[sec_q];
        y1_q[sec_q] <= mac_y;
        x_q         <= mac_y;
        if (last_sec) begin
          sec_q   <= '0;
          y_q     <= y_final;
          valid_q <= 1'b1;
          if (pend_q) begin
            coef_q[pend_addr_q] <= pend_data_q;
            pend_q <= 1'b0;
          end
        end else begin
          sec_q <= sec_q + 1'b1;
        end
      end
    end
  end

  assign ready_o = ready;
  assign y_o     = y_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - self-checking bench for the two-section biquad cascade
module tb_iir_biquad_cascade;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] x_i = '0, offset_i = '0, coef_data_i = '0;
  logic        valid_i = 1'b0, clear_i = 1'b0, coef_we_i = 1'b0;
  logic [3:0]  coef_addr_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] y_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] x;
    logic [31:0] off;
    logic [31:0] exp;
  } vec_t;
  vec_t tab[7];

  logic signed [127:0] m_coef[10];
  logic signed [127:0] m_x1[2], m_x2[2], m_y1[2], m_y2[2];

  always #5 clk = ~clk;

  iir_biquad_cascade dut (
    .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i), .ready_o(ready_o),
    .offset_i(offset_i), .clear_i(clear_i), .coef_we_i(coef_we_i),
    .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i), .y_o(y_o), .valid_o(valid_o)
  );

  function automatic logic signed [127:0] sat32(input logic signed [127:0] v);
    if (v > 128'sh7FFF_FFFF) return 128'sh7FFF_FFFF;
    if (v < -128'sh8000_0000) return -128'sh8000_0000;
    return v;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++) begin
      m_x1[s] = '0; m_x2[s] = '0; m_y1[s] = '0; m_y2[s] = '0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) m_coef[i] = '0;
    model_clear();
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    if (a < 10) m_coef[a] = 128'(signed'(d));
  endfunction

  // Difference equation per section, exact wide arithmetic, rounding half up
  function automatic logic [31:0] model_step(input logic [31:0] x, input logic [31:0] off);
    logic signed [127:0] xs, acc, y, r;
    xs = 128'(signed'(x));
    y  = '0;
    for (int s = 0; s < 2; s++) begin
      acc = m_coef[5*s] * xs + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
          - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
      y = sat32((acc + 128'sd32768) >>> 16);
      m_x2[s] = m_x1[s]; m_x1[s] = xs;
      m_y2[s] = m_y1[s]; m_y1[s] = y;
      xs = y;
    end
    r = sat32(y + 128'(signed'(off)));
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    coef_we_i = 1'b1; coef_addr_i = 4'(a); coef_data_i = d;
    @(negedge clk);
    coef_we_i = 1'b0;
    model_write(a, d);
  endtask

  task automatic xfer(input logic [31:0] x, input logic [31:0] off, input logic we,
                      input int a, input logic [31:0] d,
                      output logic [31:0] y, output int lat);
    int w;
    w = 0;
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    x_i = x; offset_i = off; valid_i = 1'b1;
    coef_we_i = we; coef_addr_i = 4'(a); coef_data_i = d;
    @(negedge clk);
    valid_i = 1'b0; coef_we_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    y = y_o;
  endtask

  task automatic run_model(input logic [31:0] x, input logic [31:0] off, input string nm);
    logic [31:0] y, e;
    int lat;
    e = model_step(x, off);
    xfer(x, off, 1'b0, 0, '0, y, lat);
    chk(nm, y, e);
    chk({nm, "_lat"}, 32'(lat), 32'd12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] y, c, x, off;
    int lat, cnt, pulses;

    tab[0] = '{32'h0001_0000, 32'h0003_0000, 32'h0000_0000, 32'h0003_0000};
    tab[1] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000};
    tab[2] = '{32'h0001_0000, 32'h0001_2345, 32'h0000_0100, 32'h0001_2445};
    tab[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
    tab[4] = '{32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tab[5] = '{32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tab[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};

    repeat (4) @(negedge clk);
    chk("rst_y", y_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ready_o), 32'h1);
    model_reset();

    wr(5, 32'h0001_0000);
    for (int i = 0; i < 7; i++) begin
      wr(0, tab[i].b0);
      void'(model_step(tab[i].x, tab[i].off));
      xfer(tab[i].x, tab[i].off, 1'b0, 0, '0, y, lat);
      chk($sformatf("tab%0d", i), y, tab[i].exp);
      chk($sformatf("tab%0d_lat", i), 32'(lat), 32'd12);
    end

    // Coefficient write in the accepting cycle: this sample still sees b0=1.0
    wr(0, 32'h0001_0000);
    void'(model_step(32'h0001_0000, 32'h0));
    xfer(32'h0001_0000, 32'h0, 1'b1, 0, 32'h0002_0000, y, lat);
    chk("same_cycle_old", y, 32'h0001_0000);
    model_write(0, 32'h0002_0000);
    void'(model_step(32'h0001_0000, 32'h0));
    xfer(32'h0001_0000, 32'h0, 1'b0, 0, '0, y, lat);
    chk("same_cycle_new", y, 32'h0002_0000);

    // Busy: sample and write attempts mid-computation must be dropped
    void'(model_step(32'h0000_8000, 32'h0));
    x_i = 32'h0000_8000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_ready0", 32'(ready_o), 32'h0);
    valid_i = 1'b1; x_i = 32'h5555_0000;
    coef_we_i = 1'b1; coef_addr_i = 4'd0; coef_data_i = 32'h7FFF_FFFF;
    repeat (4) @(negedge clk);
    chk("busy_ready1", 32'(ready_o), 32'h0);
    valid_i = 1'b0; coef_we_i = 1'b0;
    cnt = 6;
    while (!valid_o && cnt < 100) begin @(negedge clk); cnt++; end
    chk("busy_lat", 32'(cnt), 32'd12);
    chk("busy_y", y_o, 32'h0001_0000);
    pulses = 0;
    repeat (15) begin @(negedge clk); if (valid_o) pulses++; end
    chk("busy_no_extra", 32'(pulses), 32'h0);
    chk("y_hold", y_o, 32'h0001_0000);
    run_model(32'h0001_0000, 32'h0, "busy_coef");

    // Abort mid-MAC
    x_i = 32'h0003_0000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (valid_o) pulses++; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready_o), 32'h1);
    repeat (13) begin @(negedge clk); if (valid_o) pulses++; end
    chk("abort_no_valid", 32'(pulses), 32'h0);
    chk("abort_y", y_o, 32'h0);
    model_reset();
    offset_i = '0;
    run_model(32'h0003_0000, 32'h0, "abort_coef");

    // First-order section after dirtying and clearing the delay lines
    wr(0, 32'h0000_4AFA); wr(1, 32'h0000_4AFA); wr(3, 32'hFFFF_95F7); wr(5, 32'h0001_0000);
    wr(12, 32'h7FFF_FFFF);
    for (int k = 0; k < 3; k++) run_model($urandom, 32'h0, "dirty");
    clear_i = 1'b1; valid_i = 1'b1; x_i = 32'h1234_0000;
    @(negedge clk);
    clear_i = 1'b0; valid_i = 1'b0;
    chk("clear_beats_valid", 32'(ready_o), 32'h1);
    model_clear();
    void'(model_step(32'h0001_0000, 32'h0));
    xfer(32'h0001_0000, 32'h0, 1'b0, 0, '0, y, lat);
    chk("impulse0", y, 32'h0000_4AFA);
    void'(model_step(32'h0, 32'h0));
    xfer(32'h0, 32'h0, 1'b0, 0, '0, y, lat);
    chk("impulse1", y, 32'h0000_6A08);

    // Random coefficients within +/-0.5 and random samples against the model
    for (int i = 0; i < 10; i++) begin
      c = 32'($urandom_range(0, 65535)) - 32'd32768;
      wr(i, c);
    end
    for (int k = 0; k < 24; k++) begin
      x   = 32'($signed($urandom) >>> $urandom_range(0, 14));
      off = 32'($signed($urandom) >>> 12);
      run_model(x, off, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
